// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter for the memory-mapped UART0 port.
// Accepts a character plus a send-enable level, starts a frame on the
// rising edge of send-enable, and reports {done, busy} on sta_o_r.
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit
// between the last data bit and the stop bit (8E1, 11 bit-times).
module uart_tx #(
    parameter int CLKS_PER_BIT = 234
) (
    input  logic       clk_i_w,
    input  logic       rst_i_w,
    input  logic       send_i_w,
    input  logic [7:0] schar_i_w,
    output logic       tx_o_r,
    output logic [1:0] sta_o_r
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] ST_PAR   = 3'd3;
`endif
    localparam logic [2:0] ST_STOP  = 3'd4;

    localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

    logic [2:0]  state;
    logic [15:0] timer;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;
    logic        send_d;
    logic        req;
`ifdef UART_TX_PARITY_EN
    logic        par_bit;
`endif

    // A frame is requested only by a 0->1 transition of the send-enable level.
    assign req = send_i_w & ~send_d;

    // Remember the previous send-enable level for edge detection.
    always_ff @(posedge clk_i_w or negedge rst_i_w) begin
        if (!rst_i_w) begin
            send_d <= 1'b0;
        end else begin
            send_d <= send_i_w;
        end
    end

    // Frame sequencer: bit timing, shifting, line drive and status bits.
    always_ff @(posedge clk_i_w or negedge rst_i_w) begin
        if (!rst_i_w) begin
            state   <= ST_IDLE;
            timer   <= 16'd0;
            bit_idx <= 3'd0;
            shift   <= 8'd0;
            tx_o_r  <= 1'b1;
            sta_o_r <= 2'b00;
`ifdef UART_TX_PARITY_EN
            par_bit <= 1'b0;
`endif
        end else begin
            // Done is a handshake flag: it drops whenever software lowers send.
            if (!send_i_w) begin
                sta_o_r[1] <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    tx_o_r <= 1'b1;
                    if (req) begin
                        shift   <= schar_i_w;
`ifdef UART_TX_PARITY_EN
                        par_bit <= ^schar_i_w;
`endif
                        sta_o_r <= 2'b01;
                        tx_o_r  <= 1'b0;
                        timer   <= BIT_LAST;
                        state   <= ST_START;
                    end
                end

                ST_START: begin
                    if (timer == 16'd0) begin
                        timer   <= BIT_LAST;
                        tx_o_r  <= shift[0];
                        shift   <= shift >> 1;
                        bit_idx <= 3'd0;
                        state   <= ST_DATA;
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end

                ST_DATA: begin
                    if (timer == 16'd0) begin
                        timer <= BIT_LAST;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            tx_o_r <= par_bit;
                            state  <= ST_PAR;
`else
                            tx_o_r <= 1'b1;
                            state  <= ST_STOP;
`endif
                        end else begin
                            tx_o_r  <= shift[0];
                            shift   <= shift >> 1;
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end

`ifdef UART_TX_PARITY_EN
                ST_PAR: begin
                    if (timer == 16'd0) begin
                        timer  <= BIT_LAST;
                        tx_o_r <= 1'b1;
                        state  <= ST_STOP;
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
`endif

                ST_STOP: begin
                    tx_o_r <= 1'b1;
                    if (timer == 16'd0) begin
                        // Report completion only if software is still waiting.
                        sta_o_r <= {send_i_w, 1'b0};
                        state   <= ST_IDLE;
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end

                default: begin
                    tx_o_r <= 1'b1;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx with CLKS_PER_BIT = 4: table-driven frames,
// randomized frames, mid-frame input changes and reset corner cases.
module tb_uart_tx;

    localparam int C = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FL = NBITS * C;

    logic       clk_i_w = 1'b0;
    logic       rst_i_w;
    logic       send_i_w;
    logic [7:0] schar_i_w;
    logic       tx_o_r;
    logic [1:0] sta_o_r;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] ch;
        logic [7:0] mid_ch;
        bit         toggle;
        bit         end_send;
        logic [1:0] exp_end;
    } vec_t;

    vec_t tbl[8];
    vec_t rv;

    uart_tx #(.CLKS_PER_BIT(C)) dut (
        .clk_i_w  (clk_i_w),
        .rst_i_w  (rst_i_w),
        .send_i_w (send_i_w),
        .schar_i_w(schar_i_w),
        .tx_o_r   (tx_o_r),
        .sta_o_r  (sta_o_r)
    );

    always #5 clk_i_w = ~clk_i_w;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected line level in cycle n (1 = first cycle after the start edge).
    // Frame is: start 0, data LSB first, optional even parity, stop 1.
    function automatic logic line_bit(input logic [7:0] ch, input int n);
        int b;
        b = (n - 1) / C;
        if (b == 0) return 1'b0;
        if (b <= 8) return ch[b-1];
        if (NBITS == 11 && b == 9) return ^ch;
        return 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk_i_w);
        #1;
    endtask

    task automatic run_frame(input vec_t v);
        schar_i_w = v.ch;
        send_i_w  = 1'b1;
        tick();
        for (int n = 1; n <= FL; n++) begin
            chk($sformatf("tx_c%0d_ch%0h", n, v.ch), tx_o_r, line_bit(v.ch, n));
            chk($sformatf("busy_c%0d", n), sta_o_r, 2'b01);
            if (v.toggle && n == 4 * C + 1) begin
                schar_i_w = v.mid_ch;
                send_i_w  = 1'b0;
            end
            if (v.toggle && n == 4 * C + 3) send_i_w = 1'b1;
            if (!v.end_send && n == FL - 2) send_i_w = 1'b0;
            tick();
        end
        chk("end_sta", sta_o_r, v.exp_end);
        chk("end_tx", tx_o_r, 1'b1);
        for (int i = 0; i < 2 * C; i++) begin
            tick();
            chk("post_tx", tx_o_r, 1'b1);
            chk("post_sta", sta_o_r, v.exp_end);
        end
        send_i_w = 1'b0;
        tick();
        chk("clr_sta", sta_o_r, 2'b00);
        tick();
    endtask

    initial begin
        tbl[0] = '{8'h55, 8'h00, 1'b0, 1'b1, 2'b10};
        tbl[1] = '{8'hA3, 8'h00, 1'b0, 1'b1, 2'b10};
        tbl[2] = '{8'h41, 8'hFF, 1'b1, 1'b1, 2'b10};
        tbl[3] = '{8'h41, 8'hFF, 1'b1, 1'b0, 2'b00};
        tbl[4] = '{8'h07, 8'h00, 1'b0, 1'b1, 2'b10};
        tbl[5] = '{8'h03, 8'h00, 1'b0, 1'b1, 2'b10};
        tbl[6] = '{8'h00, 8'h00, 1'b0, 1'b0, 2'b00};
        tbl[7] = '{8'hFF, 8'h00, 1'b0, 1'b1, 2'b10};

        // Reset held, then released with send low: line idle, no status.
        rst_i_w   = 1'b1;
        send_i_w  = 1'b0;
        schar_i_w = 8'h00;
        #1 rst_i_w = 1'b0;
        #1;
        chk("rst_tx", tx_o_r, 1'b1);
        chk("rst_sta", sta_o_r, 2'b00);
        repeat (3) tick();
        rst_i_w = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            chk("idle_tx", tx_o_r, 1'b1);
            chk("idle_sta", sta_o_r, 2'b00);
        end

        // Table-driven frames.
        for (int i = 0; i < 8; i++) run_frame(tbl[i]);

        // Randomized frames.
        for (int i = 0; i < 8; i++) begin
            rv.ch       = 8'($urandom);
            rv.mid_ch   = 8'($urandom);
            rv.toggle   = 1'($urandom_range(0, 1));
            rv.end_send = 1'($urandom_range(0, 1));
            rv.exp_end  = rv.end_send ? 2'b10 : 2'b00;
            run_frame(rv);
        end

        // Reset during data bit 3: outputs return to idle without a clock.
        schar_i_w = 8'h00;
        send_i_w  = 1'b1;
        tick();
        repeat (4 * C) tick();
        chk("pre_rst_tx", tx_o_r, 1'b0);
        chk("pre_rst_sta", sta_o_r, 2'b01);
        rst_i_w = 1'b0;
        #1;
        chk("async_rst_tx", tx_o_r, 1'b1);
        chk("async_rst_sta", sta_o_r, 2'b00);
        send_i_w = 1'b0;
        repeat (2) tick();
        rst_i_w = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("post_rst_tx", tx_o_r, 1'b1);
            chk("post_rst_sta", sta_o_r, 2'b00);
        end

        // Send held high across reset release: first clock starts a frame.
        rst_i_w   = 1'b0;
        schar_i_w = 8'h96;
        send_i_w  = 1'b1;
        repeat (2) tick();
        chk("hold_rst_tx", tx_o_r, 1'b1);
        rst_i_w = 1'b1;
        tick();
        for (int n = 1; n <= FL; n++) begin
            chk($sformatf("rel_tx_c%0d", n), tx_o_r, line_bit(8'h96, n));
            chk($sformatf("rel_busy_c%0d", n), sta_o_r, 2'b01);
            tick();
        end
        chk("rel_end_sta", sta_o_r, 2'b10);
        send_i_w = 1'b0;
        tick();
        chk("rel_clr_sta", sta_o_r, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
